// File: rtl/ysyx_23060184_mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
// Holds the bus and field widths, the funct3 load opcodes, the AXI
// response codes and the stage state encoding.
package ysyx_23060184_mem_stage_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int WMASK_LENGTH   = 4;
    localparam int ROPCODE_LENGTH = 3;

    // Load type (funct3 encoding)
    localparam logic [ROPCODE_LENGTH-1:0] LB  = 3'b000;
    localparam logic [ROPCODE_LENGTH-1:0] LH  = 3'b001;
    localparam logic [ROPCODE_LENGTH-1:0] LW  = 3'b010;
    localparam logic [ROPCODE_LENGTH-1:0] LBU = 3'b100;
    localparam logic [ROPCODE_LENGTH-1:0] LHU = 3'b101;

    // AXI response codes
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } mem_state_e;

endpackage

// File: rtl/ysyx_23060184_mem_stage_loadext.sv
// Load data extension.
// Moves the addressed byte/halfword of the bus word down to lane 0 and
// sign- or zero-extends it according to the funct3 load type.
//   rdata    : raw word from the data bus
//   off      : byte offset within the word (address bits [1:0])
//   Ropcode  : load type
//   ext_data : extended result
module ysyx_23060184_LoadExt
    import ysyx_23060184_mem_stage_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                off,
    input  logic [ROPCODE_LENGTH-1:0] Ropcode,
    output logic [DATA_WIDTH-1:0]     ext_data
);

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted = rdata >> {off, 3'b000};
        case (Ropcode)
            LB:      ext_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            LH:      ext_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            LW:      ext_data = shifted;
            LBU:     ext_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            LHU:     ext_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: ext_data = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_23060184_mem_stage.sv
// Memory-access stage controller.
// Consumer end of the EX->MEM valid/ready handshake. Runs one AXI4-Lite
// read (loads) or write (stores) per instruction, extends load data and
// hands the completed instruction to MEM/WB under Mvalid/Wready.
//   clk, reset            : clock, asynchronous active-high reset
//   Evalid / Mready       : EX->MEM handshake (EX/MEM loads on both high)
//   MemReadM .. WriteDataM: M-stage fields held in EX/MEM
//   Mvalid / Wready       : MEM->WB handshake
//   ReadDataM, Merr       : registered load result and bus-error flag
//   ar*/r*/aw*/w*/b*      : AXI4-Lite master data port
module ysyx_23060184_mem_stage
    import ysyx_23060184_mem_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    // EX -> MEM
    input  logic                      Evalid,
    output logic                      Mready,
    input  logic                      MemReadM,
    input  logic                      MemWriteM,
    input  logic [WMASK_LENGTH-1:0]   WmaskM,
    input  logic [ROPCODE_LENGTH-1:0] RopcodeM,
    input  logic [DATA_WIDTH-1:0]     ALUResultM,
    input  logic [DATA_WIDTH-1:0]     WriteDataM,
    // MEM -> WB
    output logic                      Mvalid,
    input  logic                      Wready,
    output logic [DATA_WIDTH-1:0]     ReadDataM,
    output logic                      Merr,
    // AXI4-Lite read address
    output logic [DATA_WIDTH-1:0]     araddr,
    output logic                      arvalid,
    input  logic                      arready,
    // AXI4-Lite read data
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                rresp,
    input  logic                      rvalid,
    output logic                      rready,
    // AXI4-Lite write address
    output logic [DATA_WIDTH-1:0]     awaddr,
    output logic                      awvalid,
    input  logic                      awready,
    // AXI4-Lite write data
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [WMASK_LENGTH-1:0]   wstrb,
    output logic                      wvalid,
    input  logic                      wready,
    // AXI4-Lite write response
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready
);

    mem_state_e            state_q, state_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  merr_q, merr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  is_load, is_store;
    logic [1:0]            off;
    logic [DATA_WIDTH-1:0] word_addr;
    logic [DATA_WIDTH-1:0] load_ext;
    logic                  aw_next, w_next;

    // A set MemReadM wins if both controls are ever raised together.
    assign is_load   = MemReadM;
    assign is_store  = MemWriteM & ~MemReadM;
    assign off       = ALUResultM[1:0];
    assign word_addr = {ALUResultM[DATA_WIDTH-1:2], 2'b00};

    // EX/MEM is frozen while Mready is low, so every bus field below is
    // stable for as long as the matching valid is asserted.
    assign araddr  = word_addr;
    assign awaddr  = word_addr;
    assign wdata   = WriteDataM << {off, 3'b000};
    assign wstrb   = WmaskM << off;

    assign arvalid = (state_q == ISSUE) & is_load;
    assign awvalid = (state_q == ISSUE) & is_store & ~aw_done_q;
    assign wvalid  = (state_q == ISSUE) & is_store & ~w_done_q;
    assign rready  = (state_q == WAIT) & is_load;
    assign bready  = (state_q == WAIT) & is_store;

    assign Mvalid    = (state_q == DONE);
    assign Mready    = (state_q == IDLE) | ((state_q == DONE) & Wready);
    assign ReadDataM = rdata_q;
    assign Merr      = merr_q;

    ysyx_23060184_LoadExt u_loadext (
        .rdata    (rdata),
        .off      (off),
        .Ropcode  (RopcodeM),
        .ext_data (load_ext)
    );

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        merr_d    = merr_q;
        rdata_d   = rdata_q;
        aw_next   = aw_done_q | (awvalid & awready);
        w_next    = w_done_q | (wvalid & wready);

        case (state_q)
            IDLE: begin
                if (Evalid) begin
                    state_d = ISSUE;
                    merr_d  = 1'b0;
                end
            end
            ISSUE: begin
                if (is_load) begin
                    if (arready) state_d = WAIT;
                end else if (is_store) begin
                    // AW and W complete in either order; only leave once both have.
                    if (aw_next & w_next) begin
                        state_d   = WAIT;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        aw_done_d = aw_next;
                        w_done_d  = w_next;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (is_load & rvalid) begin
                    state_d = DONE;
                    rdata_d = load_ext;
                    merr_d  = (rresp != OKAY);
                end else if (is_store & bvalid) begin
                    state_d = DONE;
                    merr_d  = (bresp != OKAY);
                end
            end
            DONE: begin
                if (Wready) begin
                    if (Evalid) begin
                        state_d = ISSUE;
                        merr_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            merr_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            merr_q    <= merr_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_mem_stage.sv
module tb_ysyx_23060184_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        Evalid, Mready, MemReadM, MemWriteM;
    logic [3:0]  WmaskM;
    logic [2:0]  RopcodeM;
    logic [31:0] ALUResultM, WriteDataM;
    logic        Mvalid, Wready, Merr;
    logic [31:0] ReadDataM;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic        arvalid, awvalid, wvalid, rready, bready;
    logic        arready = 1'b0, awready = 1'b0, wready = 1'b0;
    logic        rvalid = 1'b0, bvalid = 1'b0;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    int errors = 0;
    int checks = 0;

    // slave latency knobs (cycles ready/valid is held off)
    int ar_lat = 0, aw_lat = 0, w_lat = 0, r_lat = 0, b_lat = 0;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] last_rd;

    ysyx_23060184_mem_stage dut (
        .clk(clk), .reset(reset),
        .Evalid(Evalid), .Mready(Mready),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .WmaskM(WmaskM),
        .RopcodeM(RopcodeM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .Mvalid(Mvalid), .Wready(Wready), .ReadDataM(ReadDataM), .Merr(Merr),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    // AXI slave: decides ready/valid on the falling edge for the next rising edge
    always @(negedge clk) begin
        arready = 1'b0;
        if (arvalid) begin if (ar_cnt >= ar_lat) arready = 1'b1; ar_cnt++; end else ar_cnt = 0;
        awready = 1'b0;
        if (awvalid) begin if (aw_cnt >= aw_lat) awready = 1'b1; aw_cnt++; end else aw_cnt = 0;
        wready = 1'b0;
        if (wvalid) begin if (w_cnt >= w_lat) wready = 1'b1; w_cnt++; end else w_cnt = 0;
        rvalid = 1'b0;
        if (rready) begin if (r_cnt >= r_lat) rvalid = 1'b1; r_cnt++; end else r_cnt = 0;
        bvalid = 1'b0;
        if (bready) begin if (b_cnt >= b_lat) bvalid = 1'b1; b_cnt++; end else b_cnt = 0;
    end

    // scoreboard consumer: every MEM->WB transfer pops one expectation
    always begin
        @(negedge clk);
        #1;
        if (!reset && Mvalid && Wready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_mvalid got=1 exp=0");
            end else begin
                mon_e = sb.pop_front();
                if (ReadDataM !== mon_e.rd) begin
                    errors++;
                    $display("FAIL sb_readdata got=%h exp=%h", ReadDataM, mon_e.rd);
                end
                checks++;
                if (Merr !== mon_e.err) begin
                    errors++;
                    $display("FAIL sb_merr got=%b exp=%b", Merr, mon_e.err);
                end
            end
        end
    end

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    // with the new EX/MEM contents applied.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] mask,
                         input logic [2:0] rop, input logic [31:0] exp_rd,
                         input logic exp_err);
        int n = 0;
        exp_t e;
        Evalid = 1'b1;
        sample();
        while (!Mready && n < 50) begin sample(); n++; end
        if (!Mready) begin
            errors++; checks++;
            $display("FAIL accept_timeout got=0 exp=1");
        end
        @(posedge clk);
        #1;
        Evalid = 1'b0;
        MemReadM = rd; MemWriteM = wr; ALUResultM = addr;
        WriteDataM = wd; WmaskM = mask; RopcodeM = rop;
        if (rd) last_rd = exp_rd;
        e.rd = last_rd;
        e.err = exp_err;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin sample(); n++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got=%0d exp=0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; Evalid = 1'b0; Wready = 1'b1;
        MemReadM = 1'b0; MemWriteM = 1'b0; WmaskM = 4'h0; RopcodeM = 3'b0;
        ALUResultM = 32'h0; WriteDataM = 32'h0; rdata = 32'h0;
        rresp = 2'b00; bresp = 2'b00; last_rd = 32'h0;
        #2;
        checks++;
        if ({Mready, Mvalid, Merr} !== 3'b100) begin
            errors++; $display("FAIL reset_handshake got=%b exp=100", {Mready, Mvalid, Merr});
        end
        checks++;
        if (ReadDataM !== 32'h0) begin
            errors++; $display("FAIL reset_readdata got=%h exp=00000000", ReadDataM);
        end
        checks++;
        if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
            errors++; $display("FAIL reset_axi got=%b exp=00000", {arvalid, awvalid, wvalid, rready, bready});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        sample();
        checks++;
        if ({Mready, Mvalid} !== 2'b10) begin
            errors++; $display("FAIL idle_after_reset got=%b exp=10", {Mready, Mvalid});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_nonmem();
        issue(1'b0, 1'b0, 32'h0000_1234, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0);
        sample();  // T1
        checks++;
        if ({Mready, Mvalid} !== 2'b00) begin
            errors++; $display("FAIL nonmem_t1 got=%b exp=00", {Mready, Mvalid});
        end
        sample();  // T2
        checks++;
        if ({Mready, Mvalid} !== 2'b11) begin
            errors++; $display("FAIL nonmem_t2 got=%b exp=11", {Mready, Mvalid});
        end
        sample();  // T3
        checks++;
        if ({Mready, Mvalid} !== 2'b10) begin
            errors++; $display("FAIL nonmem_t3 got=%b exp=10", {Mready, Mvalid});
        end
        wait_drain();
    endtask

    task automatic test_loads();
        logic [31:0] t_addr[7] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002, 32'h8000_0002,
                                   32'h8000_0000, 32'h8000_0001, 32'h8000_0004};
        logic [31:0] t_data[7] = '{32'h80FF_FF7F, 32'h80FF_FF7F, 32'h8001_1234, 32'h8001_1234,
                                   32'h8001_1234, 32'h1234_5678, 32'hCAFE_F00D};
        logic [2:0]  t_rop[7]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b011};
        logic [31:0] t_exp[7]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
                                   32'h8001_1234, 32'h0000_0056, 32'hCAFE_F00D};
        for (int i = 0; i < 7; i++) begin
            rdata = t_data[i];
            issue(1'b1, 1'b0, t_addr[i], 32'h0, 4'h0, t_rop[i], t_exp[i], 1'b0);
            if (i == 0) begin
                sample();  // T1: address phase
                checks++;
                if ({arvalid, araddr} !== {1'b1, 32'h8000_0000}) begin
                    errors++; $display("FAIL load_ar_t1 got=%b/%h exp=1/80000000", arvalid, araddr);
                end
                sample();  // T2: data phase
                checks++;
                if ({arvalid, rready, Mvalid} !== 3'b010) begin
                    errors++; $display("FAIL load_r_t2 got=%b exp=010", {arvalid, rready, Mvalid});
                end
                sample();  // T3
                checks++;
                if (Mvalid !== 1'b1) begin
                    errors++; $display("FAIL load_mvalid_t3 got=%b exp=1", Mvalid);
                end
            end
            wait_drain();
        end
    endtask

    task automatic test_stores();
        logic [31:0] s_addr[3]  = '{32'h8000_0002, 32'h8000_0003, 32'h8000_0001};
        logic [31:0] s_data[3]  = '{32'h0000_BEEF, 32'h0000_00A5, 32'h1122_3344};
        logic [3:0]  s_mask[3]  = '{4'h3, 4'h1, 4'hF};
        logic [31:0] s_wdata[3] = '{32'hBEEF_0000, 32'hA500_0000, 32'h2233_4400};
        logic [3:0]  s_wstrb[3] = '{4'hC, 4'h8, 4'hE};
        int          s_aw[3]    = '{0, 2, 0};
        int          s_w[3]     = '{3, 0, 0};
        for (int i = 0; i < 3; i++) begin
            int  cyc = 0, b_cyc = -1, m_cyc = -1;
            logic aw_seen = 1'b0, w_seen = 1'b0, bad = 1'b0;
            aw_lat = s_aw[i]; w_lat = s_w[i];
            issue(1'b0, 1'b1, s_addr[i], s_data[i], s_mask[i], 3'b010, 32'h0, 1'b0);
            while (m_cyc < 0 && cyc < 30) begin
                sample();
                cyc++;
                if (awvalid && awaddr !== {s_addr[i][31:2], 2'b00}) bad = 1'b1;
                if (wvalid && (wdata !== s_wdata[i] || wstrb !== s_wstrb[i])) bad = 1'b1;
                if (bready && !(aw_seen && w_seen)) bad = 1'b1;
                if (awvalid && awready) aw_seen = 1'b1;
                if (wvalid && wready) w_seen = 1'b1;
                if (bvalid && bready) b_cyc = cyc;
                if (Mvalid) m_cyc = cyc;
            end
            checks++;
            if (bad) begin
                errors++; $display("FAIL store%0d_bus got=%h/%h exp=%h/%h", i, wdata, wstrb, s_wdata[i], s_wstrb[i]);
            end
            checks++;
            if (!(aw_seen && w_seen) || b_cyc < 0 || m_cyc != b_cyc + 1) begin
                errors++; $display("FAIL store%0d_timing got=b%0d/m%0d exp=m=b+1", i, b_cyc, m_cyc);
            end
            if (i == 2) begin
                checks++;  // zero-wait store: both handshakes at T1, B at T2, Mvalid at T3
                if (b_cyc != 2 || m_cyc != 3) begin
                    errors++; $display("FAIL store_zero_wait got=b%0d/m%0d exp=b2/m3", b_cyc, m_cyc);
                end
            end
            wait_drain();
        end
        aw_lat = 0; w_lat = 0;
    endtask

    task automatic test_errors();
        rresp = 2'b10; rdata = 32'hDEAD_BEEF;
        issue(1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 3'b010, 32'hDEAD_BEEF, 1'b1);
        wait_drain();
        rresp = 2'b00; rdata = 32'h0102_0304;
        issue(1'b1, 1'b0, 32'h8000_0014, 32'h0, 4'h0, 3'b010, 32'h0102_0304, 1'b0);
        wait_drain();
        bresp = 2'b10;
        issue(1'b0, 1'b1, 32'h8000_0020, 32'h5555_AAAA, 4'hF, 3'b010, 32'h0, 1'b1);
        wait_drain();
        bresp = 2'b00;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        Wready = 1'b0;
        rdata = 32'h7FFF_0000;
        issue(1'b1, 1'b0, 32'h8000_0002, 32'h0, 4'h0, 3'b001, 32'h0000_7FFF, 1'b0);
        sample();
        while (!Mvalid && n < 20) begin sample(); n++; end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) sample();
            checks++;
            if ({Mvalid, Mready, Merr, ReadDataM} !== {3'b100, 32'h0000_7FFF}) begin
                errors++; $display("FAIL stall%0d got=%b%b%b/%h exp=100/00007fff", k, Mvalid, Mready, Merr, ReadDataM);
            end
        end
        @(posedge clk); #1;
        Wready = 1'b1; Evalid = 1'b1;
        sample();
        checks++;
        if (Mready !== 1'b1) begin
            errors++; $display("FAIL b2b_mready got=%b exp=1", Mready);
        end
        @(posedge clk); #1;
        Evalid = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; ALUResultM = 32'h0;
        mon_e.rd = last_rd; mon_e.err = 1'b0;
        sb.push_back(mon_e);
        sample();
        checks++;
        if ({Mvalid, Mready} !== 2'b00) begin
            errors++; $display("FAIL b2b_issue got=%b exp=00", {Mvalid, Mready});
        end
        sample();
        checks++;
        if (Mvalid !== 1'b1) begin
            errors++; $display("FAIL b2b_done got=%b exp=1", Mvalid);
        end
        wait_drain();
    endtask

    task automatic test_async_reset();
        ar_lat = 5; rdata = 32'h1111_1111;
        issue(1'b1, 1'b0, 32'h8000_0040, 32'h0, 4'h0, 3'b010, 32'h1111_1111, 1'b0);
        sample();
        checks++;
        if (arvalid !== 1'b1) begin
            errors++; $display("FAIL rst_pre_arvalid got=%b exp=1", arvalid);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({arvalid, Mready, Mvalid, rready} !== 4'b0100) begin
            errors++; $display("FAIL async_reset got=%b exp=0100", {arvalid, Mready, Mvalid, rready});
        end
        sb.delete();
        last_rd = 32'h0;
        ar_lat = 0;
        @(posedge clk); #2;
        reset = 1'b0;
        issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_loads();
        test_stores();
        test_errors();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
